// File: rtl/ipml_prefetch_fifo_rd_arbiter.sv
// Round-robin burst scheduler that drains N_CH prefetch FIFO read ports into one tagged valid/ready stream.
// Optional PFA_STATS_EN adds per-channel saturating burst/starvation counters.
module ipml_prefetch_fifo_rd_arbiter #(
  parameter  int N_CH      = 4,
  parameter  int DATA_W    = 32,
  parameter  int BURST_LEN = 16,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic [N_CH*DATA_W-1:0] ch_rd_data,
  input  logic [N_CH-1:0]        ch_rd_vld,
  output logic [N_CH-1:0]        ch_rd_en,
  input  logic [N_CH-1:0]        ch_enable,
  output logic [DATA_W-1:0]      m_data,
  output logic [CH_W-1:0]        m_ch,
  output logic                   m_last,
  output logic                   m_vld,
  input  logic                   m_rdy,
`ifdef PFA_STATS_EN
  output logic [N_CH*16-1:0]     stat_bursts,
  output logic [N_CH*16-1:0]     stat_starve,
`endif
  output logic                   busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {ARB, BURST, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [CH_W-1:0]    grant;
  logic [CNT_W-1:0]   beat_cnt;
  logic               h_vld;
  logic [DATA_W-1:0]  h_data;
  logic [CH_W-1:0]    h_ch;

  logic [N_CH-1:0]    req;
  logic               arb_found;
  logic [CH_W-1:0]    arb_ch;
  logic               o_free;
  logic               cur_vld, cur_en, below_len;
  logic               pop, burst_end, h_to_o, last_to_o;
  logic [DATA_W-1:0]  sel_data;

  // The grant register doubles as the round-robin pointer: search starts just after it.
  always_comb begin
    logic [CH_W-1:0] cand;
    req       = ch_enable & ch_rd_vld;
    arb_found = 1'b0;
    arb_ch    = grant;
    cand      = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = CH_W'((int'(grant) + i) % N_CH);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_ch    = cand;
      end
    end
  end

  always_comb begin
    o_free    = ~m_vld | m_rdy;
    cur_vld   = ch_rd_vld[grant];
    cur_en    = ch_enable[grant];
    below_len = (beat_cnt < CNT_W'(BURST_LEN));
    sel_data  = ch_rd_data[int'(grant)*DATA_W +: DATA_W];
    pop       = (state == BURST) & cur_vld & cur_en & below_len & (~h_vld | o_free);
    burst_end = (state == BURST) & ~(cur_vld & cur_en & below_len);
    h_to_o    = pop & h_vld;
    // The held beat becomes the last beat once the burst is known to be over.
    last_to_o = h_vld & o_free & (burst_end | (state == FLUSH));
    ch_rd_en  = '0;
    if (pop) ch_rd_en[grant] = 1'b1;
    busy      = (state != ARB) | h_vld | m_vld;

    state_nxt = state;
    case (state)
      ARB:     if (arb_found) state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = (h_vld & ~o_free) ? FLUSH : ARB;
      FLUSH:   if (o_free) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state    <= ARB;
      grant    <= CH_W'(N_CH - 1);
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB && arb_found) begin
        grant    <= arb_ch;
        beat_cnt <= '0;
      end else if (pop) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      h_vld  <= 1'b0;
      h_data <= '0;
      h_ch   <= '0;
    end else if (pop) begin
      h_vld  <= 1'b1;
      h_data <= sel_data;
      h_ch   <= grant;
    end else if (last_to_o) begin
      h_vld  <= 1'b0;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      m_vld  <= 1'b0;
      m_data <= '0;
      m_ch   <= '0;
      m_last <= 1'b0;
    end else if (h_to_o || last_to_o) begin
      m_vld  <= 1'b1;
      m_data <= h_data;
      m_ch   <= h_ch;
      m_last <= last_to_o;
    end else if (m_rdy) begin
      m_vld  <= 1'b0;
    end
  end

`ifdef PFA_STATS_EN
  logic        starve_end;
  logic [15:0] bursts_cnt [N_CH];
  logic [15:0] starve_cnt [N_CH];

  assign starve_end = burst_end & ~cur_vld & below_len;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int k = 0; k < N_CH; k++) begin
        bursts_cnt[k] <= '0;
        starve_cnt[k] <= '0;
      end
    end else begin
      if (last_to_o && bursts_cnt[h_ch] != 16'hFFFF)
        bursts_cnt[h_ch] <= bursts_cnt[h_ch] + 16'd1;
      if (starve_end && starve_cnt[grant] != 16'hFFFF)
        starve_cnt[grant] <= starve_cnt[grant] + 16'd1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_stats
    assign stat_bursts[k*16 +: 16] = bursts_cnt[k];
    assign stat_starve[k*16 +: 16] = starve_cnt[k];
  end
`endif

endmodule
